// File: rtl/mem_responder.sv
// Word-organised RAM responder for the CPU data bus with byte enables and range/alignment errors.
// Latency: ready_o pulses in the (WAIT_STATES+1)th cycle after the accepting edge.
// Backpressure: busy_o is high from acceptance through the ready cycle; req_i is ignored meanwhile.
module mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0000_1000),
    parameter int                    WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           data_i,
    input  logic [3:0]            be_i,
    output logic                  ready_o,
    output logic [31:0]           data_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_data;
    logic [3:0]            lat_be;

    logic [31:0]           mem [DEPTH_WORDS];

    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_data;
    logic [3:0]            cur_be;
    logic [ADDR_WIDTH:0]   diff;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [IDX_W-1:0]      idx;
    logic                  acc_err;
    logic                  enter_resp;

    // With zero wait states the response is built on the accepting edge, so take the live inputs.
    always_comb begin
        cur_we   = (state == ST_IDLE) ? we_i   : lat_we;
        cur_addr = (state == ST_IDLE) ? addr_i : lat_addr;
        cur_data = (state == ST_IDLE) ? data_i : lat_data;
        cur_be   = (state == ST_IDLE) ? be_i   : lat_be;
    end

    // One extra bit on the subtraction turns an address below the base into a borrow, not a wrap.
    assign diff     = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    assign word_off = diff[ADDR_WIDTH-1:0] >> 2;
    assign idx      = word_off[IDX_W-1:0];
    assign acc_err  = (cur_addr[1:0] != 2'b00) || diff[ADDR_WIDTH] ||
                      (word_off >= ADDR_WIDTH'(DEPTH_WORDS));

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        ready_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_i) begin
                    state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                busy_o    = 1'b1;
                ready_o   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_resp = reset && (state != ST_RESP) && (state_nxt == ST_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_data <= 32'd0;
            lat_be   <= 4'd0;
            data_o   <= 32'd0;
            err_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_i) begin
                lat_we   <= we_i;
                lat_addr <= addr_i;
                lat_data <= data_i;
                lat_be   <= be_i;
                cnt      <= 4'(WAIT_STATES);
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_o  <= acc_err;
                data_o <= (acc_err || cur_we) ? 32'd0 : mem[idx];
            end else if (state == ST_RESP) begin
                err_o  <= 1'b0;
                data_o <= 32'd0;
            end
        end
    end

    // Storage survives reset; the commit is gated by enter_resp, which is low while reset is held.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

endmodule
